spi_flash_cfg_loader: RTL and testbench
=======================================

Name: spi_flash_cfg_loader

Overview:
- Autonomous bitstream loader that feeds the eFPGA self-write configuration port (SelfWriteStrobe / SelfWriteData), which is currently tied off at the top level.
- Reads a bitstream image from an external SPI NOR flash at power-up or on request, validates the header, and streams 32-bit words into the fabric.
- Flags completion or error for the top level's DONE/LED logic.
- Sits between the flash pads and eFPGA_top, in the fabric config clock domain.

Parameters:
- FLASH_ADDR, 24'h100000, byte address of image header in flash.
- CLK_DIV, 2, SCLK half-period in CLK cycles (>=1).
- MAX_WORDS, 32'd65536, largest accepted payload length in words.
- MAGIC, 32'hFAB0C0DE, required first header word.

Ports:
- CLK  in  1  fabric config clock
- resetn  in  1  asynchronous active-low reset
- boot_en  in  1  sampled in IDLE; if 1, load starts automatically once after reset release
- start  in  1  single-cycle pulse; starts a load from IDLE, DONE or ERROR
- spi_miso  in  1  flash data out
- spi_sclk  out  1  SPI clock, mode 0
- spi_cs_n  out  1  flash chip select, active low
- spi_mosi  out  1  flash data in
- SelfWriteData  out  32  configuration word
- SelfWriteStrobe  out  1  one-cycle strobe, SelfWriteData valid
- busy  out  1  load in progress
- done  out  1  sticky, set on successful load
- error  out  1  sticky, set on bad magic or length
- words_loaded  out  32  count of strobed payload words

Behaviour:
- Reset values (async on resetn low, from any state): spi_cs_n=1, spi_sclk=0, spi_mosi=0, SelfWriteStrobe=0, SelfWriteData=0, busy=0, done=0, error=0, words_loaded=0, state=IDLE, auto-boot flag armed.
- States: IDLE, CS_SETUP, CMD, HDR_MAGIC, HDR_LEN, DATA, CS_HOLD, DONE, ERROR.
- IDLE -> CS_SETUP when (armed & boot_en) or start. Armed clears on leaving IDLE. On entry, clears done, error and words_loaded.
- CS_SETUP: spi_cs_n=0, hold CLK_DIV cycles, then go to CMD. busy=1 in every state except IDLE, DONE and ERROR.
- SPI bit timing (all shift states):
  - Each bit is a low phase of CLK_DIV cycles (spi_mosi updated on the first cycle) followed by a high phase of CLK_DIV cycles.
  - spi_miso is sampled on the cycle spi_sclk returns 1->0, i.e. the end of the high phase.
  - Bits are MSB first. spi_sclk is never high while spi_cs_n=1.
- CMD: shifts 32 bits = 8'h03 followed by FLASH_ADDR[23:0]. spi_mosi=0 in all later states.
- HDR_MAGIC: shifts in 32 bits. If the word != MAGIC -> CS_HOLD, then ERROR.
- HDR_LEN: shifts in 32-bit length L.
  - L==0 -> CS_HOLD, then DONE.
  - L>MAX_WORDS -> CS_HOLD, then ERROR.
  - Otherwise -> DATA.
- DATA:
  - After the 32nd bit of each word is sampled, the next cycle drives SelfWriteData=word with SelfWriteStrobe=1 for exactly one cycle, and words_loaded increments in that same cycle.
  - SelfWriteData holds its value until the next strobe.
  - Shifting of the next word continues without a gap; the strobe spacing is therefore >= 64*CLK_DIV cycles.
  - After word L is strobed -> CS_HOLD.
- CS_HOLD: spi_sclk=0 for CLK_DIV cycles, then spi_cs_n=1 for CLK_DIV cycles, then the pending target state (DONE or ERROR).
- DONE / ERROR: busy=0; done or error held at 1. start re-launches the load. boot_en is ignored after the first launch.
- start while busy: ignored.
- start in the same cycle boot_en auto-launches: a single launch only.
- Reset mid-load: immediate return to reset values. No partial strobe, and CS is deasserted.
- words_loaded wraps never; it is bounded by MAX_WORDS.

Test Plan:
- Flash model: MAGIC, L=3, words 32'h11111111, 32'h22222222, 32'h33333333; boot_en=1, CLK_DIV=2 -> MOSI stream 0x03,0x10,0x00,0x00; exactly 3 strobes with those data in order; each strobe 1 cycle wide; strobes spaced 128 CLK; done=1, error=0, words_loaded=3, spi_cs_n=1 at end.
- Header word 32'hDEADBEEF -> no strobes, error=1, done=0, busy=0, CS released within 2*CLK_DIV cycles after the 64th read bit.
- L=0 -> done=1, zero strobes. L=MAX_WORDS+1 -> error=1, zero strobes.
- boot_en=0 then start pulse after 10 cycles -> load begins (spi_cs_n falls) on the next cycle. A second start pulse during DATA -> no effect, total strobe count unchanged.
- resetn pulled low after 2 of 3 words -> all outputs at reset values asynchronously. With boot_en=1 on release, a full reload gives 3 fresh strobes and words_loaded=3.
- CLK_DIV=1 -> SCLK period 2 CLK, correct data, and spi_sclk=0 whenever spi_cs_n=1 (assertion throughout).

Source files
------------

// File: rtl/spi_flash_cfg_loader.sv
// rtl/spi_flash_cfg_loader.sv - SPI NOR bitstream loader for the eFPGA self-write port
module spi_flash_cfg_loader #(
  parameter logic [23:0] FLASH_ADDR = 24'h100000,
  parameter int          CLK_DIV    = 2,
  parameter logic [31:0] MAX_WORDS  = 32'd65536,
  parameter logic [31:0] MAGIC      = 32'hFAB0C0DE
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic        boot_en,
  input  logic        start,
  input  logic        spi_miso,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  output logic [31:0] SelfWriteData,
  output logic        SelfWriteStrobe,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] words_loaded
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_CMD,
    ST_HDR_MAGIC,
    ST_HDR_LEN,
    ST_DATA,
    ST_CS_HOLD,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] div_cnt;
  logic          phase;
  logic [4:0]    bit_cnt;
  logic [31:0]   shift_sr;
  logic [31:0]   cmd_sr;
  logic [31:0]   len_q;
  logic          pend_err;
  logic          armed;

  logic          shifting;
  logic          tick;
  logic          bit_end;
  logic          word_end;
  logic          last_word;
  logic          leaving;
  logic [31:0]   rx_word;

  assign shifting  = (state == ST_CMD) || (state == ST_HDR_MAGIC) ||
                     (state == ST_HDR_LEN) || (state == ST_DATA);
  assign tick      = (div_cnt == DIV_LAST);
  // miso is taken on the edge where sclk drops, i.e. the last high-phase cycle
  assign bit_end   = shifting && phase && tick;
  assign word_end  = bit_end && (bit_cnt == 5'd31);
  assign rx_word   = {shift_sr[30:0], spi_miso};
  assign last_word = ((words_loaded + 32'd1) == len_q);
  assign leaving   = (state_nxt != state);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if ((armed && boot_en) || start) state_nxt = ST_CS_SETUP;
      ST_CS_SETUP:  if (tick) state_nxt = ST_CMD;
      ST_CMD:       if (word_end) state_nxt = ST_HDR_MAGIC;
      ST_HDR_MAGIC: if (word_end) state_nxt = (rx_word == MAGIC) ? ST_HDR_LEN : ST_CS_HOLD;
      ST_HDR_LEN: begin
        if (word_end) begin
          state_nxt = ((rx_word == 32'd0) || (rx_word > MAX_WORDS)) ? ST_CS_HOLD : ST_DATA;
        end
      end
      ST_DATA:      if (word_end && last_word) state_nxt = ST_CS_HOLD;
      ST_CS_HOLD:   if (phase && tick) state_nxt = pend_err ? ST_ERROR : ST_DONE;
      ST_DONE:      if (start) state_nxt = ST_CS_SETUP;
      ST_ERROR:     if (start) state_nxt = ST_CS_SETUP;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    // CS_HOLD keeps CS low with sclk idle for the first half, then releases it
    spi_cs_n = !((state == ST_CS_SETUP) || shifting || ((state == ST_CS_HOLD) && !phase));
    spi_sclk = shifting && phase;
    spi_mosi = (state == ST_CMD) && cmd_sr[31];
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      div_cnt         <= '0;
      phase           <= 1'b0;
      bit_cnt         <= 5'd0;
      shift_sr        <= 32'd0;
      cmd_sr          <= 32'd0;
      len_q           <= 32'd0;
      pend_err        <= 1'b0;
      armed           <= 1'b1;
      SelfWriteData   <= 32'd0;
      SelfWriteStrobe <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      words_loaded    <= 32'd0;
    end else begin
      SelfWriteStrobe <= 1'b0;

      if ((state == ST_IDLE) && leaving) begin
        armed <= 1'b0;
      end

      if ((state_nxt == ST_CS_SETUP) && leaving) begin
        done         <= 1'b0;
        error        <= 1'b0;
        words_loaded <= 32'd0;
      end

      // phase timers restart on every state change; DATA words run back to back
      if (leaving) begin
        div_cnt <= '0;
        phase   <= 1'b0;
        bit_cnt <= 5'd0;
      end else if (busy) begin
        if (tick) begin
          div_cnt <= '0;
          phase   <= ~phase;
          if (phase) begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end

      if (bit_end) begin
        shift_sr <= rx_word;
      end

      if ((state_nxt == ST_CMD) && leaving) begin
        cmd_sr <= {8'h03, FLASH_ADDR};
      end else if ((state == ST_CMD) && bit_end) begin
        cmd_sr <= {cmd_sr[30:0], 1'b0};
      end

      if ((state == ST_HDR_MAGIC) && word_end) begin
        pend_err <= (rx_word != MAGIC);
      end

      if ((state == ST_HDR_LEN) && word_end) begin
        len_q    <= rx_word;
        pend_err <= (rx_word > MAX_WORDS);
      end

      if ((state == ST_DATA) && word_end) begin
        SelfWriteData   <= rx_word;
        SelfWriteStrobe <= 1'b1;
        words_loaded    <= words_loaded + 32'd1;
      end

      if ((state == ST_CS_HOLD) && leaving) begin
        if (pend_err) begin
          error <= 1'b1;
        end else begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_cfg_loader.sv
// tb/tb_spi_flash_cfg_loader.sv - directed bench for spi_flash_cfg_loader
module tb_spi_flash_cfg_loader;

  logic        clk = 1'b0;
  logic        resetn_a = 1'b0;
  logic        resetn_b = 1'b0;
  logic        boot_en = 1'b1;
  logic        start = 1'b0;

  logic        miso_a, sclk_a, cs_n_a, mosi_a, strobe_a, busy_a, done_a, error_a;
  logic [31:0] data_a, words_a;
  logic        miso_b, sclk_b, cs_n_b, mosi_b, strobe_b, busy_b, done_b, error_b;
  logic [31:0] data_b, words_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] img [0:4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_flash_cfg_loader #(.CLK_DIV(2)) dut_a (
    .CLK(clk), .resetn(resetn_a), .boot_en(boot_en), .start(start), .spi_miso(miso_a),
    .spi_sclk(sclk_a), .spi_cs_n(cs_n_a), .spi_mosi(mosi_a), .SelfWriteData(data_a),
    .SelfWriteStrobe(strobe_a), .busy(busy_a), .done(done_a), .error(error_a),
    .words_loaded(words_a)
  );

  spi_flash_cfg_loader #(.CLK_DIV(1)) dut_b (
    .CLK(clk), .resetn(resetn_b), .boot_en(boot_en), .start(start), .spi_miso(miso_b),
    .spi_sclk(sclk_b), .spi_cs_n(cs_n_b), .spi_mosi(mosi_b), .SelfWriteData(data_b),
    .SelfWriteStrobe(strobe_b), .busy(busy_b), .done(done_b), .error(error_b),
    .words_loaded(words_b)
  );

  // flash model: first data bit appears on the fall of the 32nd command clock
  function automatic logic fbit(input int n);
    int k;
    if (n < 32) return 1'b0;
    k = n - 32;
    if (k >= 160) return 1'b0;
    return img[k / 32][31 - (k % 32)];
  endfunction

  int  falls_a = 0, falls_b = 0;
  time t64_a = 0, tcs_a = 0;

  always @(negedge sclk_a or posedge cs_n_a) begin
    if (cs_n_a) begin
      falls_a = 0;
      tcs_a   = $time;
    end else begin
      falls_a = falls_a + 1;
      if (falls_a == 64) t64_a = $time;
    end
  end

  always @(negedge sclk_b or posedge cs_n_b) begin
    if (cs_n_b) falls_b = 0;
    else falls_b = falls_b + 1;
  end

  always_comb miso_a = fbit(falls_a);
  always_comb miso_b = fbit(falls_b);

  int          rises_a = 0, rises_b = 0;
  logic [31:0] mosi_w_a = 32'd0, mosi_w_b = 32'd0;
  time         tr0_b = 0, tr1_b = 0;

  always @(posedge sclk_a or negedge cs_n_a) begin
    if (sclk_a) begin
      if (rises_a < 32) mosi_w_a = {mosi_w_a[30:0], mosi_a};
      rises_a = rises_a + 1;
    end else begin
      rises_a = 0;
    end
  end

  always @(posedge sclk_b or negedge cs_n_b) begin
    if (sclk_b) begin
      if (rises_b < 32) mosi_w_b = {mosi_w_b[30:0], mosi_b};
      if (rises_b == 0) tr0_b = $time;
      if (rises_b == 1) tr1_b = $time;
      rises_b = rises_b + 1;
    end else begin
      rises_b = 0;
    end
  end

  int          ns_a = 0, ns_b = 0, werr_a = 0, werr_b = 0, viol_a = 0, viol_b = 0;
  logic        prev_a = 1'b0, prev_b = 1'b0;
  logic [31:0] sdat_a [32];
  logic [31:0] sdat_b [32];
  int          scyc_a [32];
  int          scyc_b [32];

  always @(negedge clk) begin
    if (strobe_a) begin
      sdat_a[ns_a % 32] = data_a;
      scyc_a[ns_a % 32] = cyc;
      ns_a = ns_a + 1;
      if (prev_a) werr_a = werr_a + 1;
    end
    prev_a = strobe_a;
    if (strobe_b) begin
      sdat_b[ns_b % 32] = data_b;
      scyc_b[ns_b % 32] = cyc;
      ns_b = ns_b + 1;
      if (prev_b) werr_b = werr_b + 1;
    end
    prev_b = strobe_b;
    if (sclk_a && cs_n_a) viol_a = viol_a + 1;
    if (sclk_b && cs_n_b) viol_b = viol_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rst_a(input string tag);
    check({tag, "_cs_n"}, cs_n_a, 1);
    check({tag, "_sclk"}, sclk_a, 0);
    check({tag, "_mosi"}, mosi_a, 0);
    check({tag, "_strobe"}, strobe_a, 0);
    check({tag, "_data"}, data_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_error"}, error_a, 0);
    check({tag, "_words"}, words_a, 0);
  endtask

  task automatic wait_load(input bit use_b, input string tag);
    int n;
    n = 0;
    while (!(use_b ? busy_b : busy_a) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_rise"}, use_b ? busy_b : busy_a, 1);
    n = 0;
    while ((use_b ? busy_b : busy_a) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_fall"}, use_b ? busy_b : busy_a, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    img[0] = 32'hFAB0C0DE;
    img[1] = 32'd3;
    img[2] = 32'h11111111;
    img[3] = 32'h22222222;
    img[4] = 32'h33333333;

    repeat (3) @(negedge clk);
    check_rst_a("reset");

    // auto boot, nominal three-word image
    resetn_a = 1'b1;
    wait_load(0, "boot");
    check("boot_mosi_cmd", mosi_w_a, 32'h03100000);
    check("boot_strobes", ns_a, 3);
    check("boot_w0", sdat_a[0], 32'h11111111);
    check("boot_w1", sdat_a[1], 32'h22222222);
    check("boot_w2", sdat_a[2], 32'h33333333);
    check("boot_gap01", scyc_a[1] - scyc_a[0], 128);
    check("boot_gap12", scyc_a[2] - scyc_a[1], 128);
    check("boot_width", werr_a, 0);
    check("boot_done", done_a, 1);
    check("boot_error", error_a, 0);
    check("boot_words", words_a, 3);
    check("boot_cs_n", cs_n_a, 1);

    // bad magic
    img[0] = 32'hDEADBEEF;
    base = ns_a;
    pulse_start();
    wait_load(0, "magic");
    check("magic_strobes", ns_a - base, 0);
    check("magic_error", error_a, 1);
    check("magic_done", done_a, 0);
    check("magic_busy", busy_a, 0);
    check("magic_cs_rel", ((tcs_a > t64_a) && (tcs_a - t64_a <= 40)) ? 1 : 0, 1);
    img[0] = 32'hFAB0C0DE;

    // zero length
    img[1] = 32'd0;
    base = ns_a;
    pulse_start();
    wait_load(0, "len0");
    check("len0_done", done_a, 1);
    check("len0_error", error_a, 0);
    check("len0_strobes", ns_a - base, 0);
    check("len0_words", words_a, 0);

    // oversized length
    img[1] = 32'd65537;
    base = ns_a;
    pulse_start();
    wait_load(0, "lenmax");
    check("lenmax_error", error_a, 1);
    check("lenmax_done", done_a, 0);
    check("lenmax_strobes", ns_a - base, 0);
    img[1] = 32'd3;

    // no auto boot, start by pulse, second start in DATA ignored
    @(negedge clk);
    resetn_a = 1'b0;
    boot_en = 1'b0;
    @(negedge clk);
    resetn_a = 1'b1;
    repeat (10) @(negedge clk);
    check("noboot_busy", busy_a, 0);
    check("noboot_cs_n", cs_n_a, 1);
    base = ns_a;
    pulse_start();
    check("start_cs_fall", cs_n_a, 0);
    n = 0;
    while (ns_a - base < 1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("start_first_strobe", ns_a - base, 1);
    pulse_start();
    wait_load(0, "restart");
    check("restart_strobes", ns_a - base, 3);
    check("restart_words", words_a, 3);
    check("restart_done", done_a, 1);

    // asynchronous reset after two words, then fresh auto boot
    boot_en = 1'b1;
    base = ns_a;
    pulse_start();
    n = 0;
    while (ns_a - base < 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("midrst_two_strobes", ns_a - base, 2);
    @(posedge clk);
    #3 resetn_a = 1'b0;
    #1 check_rst_a("midrst");
    @(negedge clk);
    check("midrst_no_partial", ns_a - base, 2);
    resetn_a = 1'b1;
    base = ns_a;
    wait_load(0, "reload");
    check("reload_strobes", ns_a - base, 3);
    check("reload_words", words_a, 3);
    check("reload_last", data_a, 32'h33333333);
    check("reload_done", done_a, 1);
    check("sclk_cs_a", viol_a, 0);

    // CLK_DIV = 1 instance
    resetn_b = 1'b1;
    wait_load(1, "div1");
    check("div1_mosi_cmd", mosi_w_b, 32'h03100000);
    check("div1_sclk_period", 32'(tr1_b - tr0_b), 20);
    check("div1_strobes", ns_b, 3);
    check("div1_w0", sdat_b[0], 32'h11111111);
    check("div1_w1", sdat_b[1], 32'h22222222);
    check("div1_w2", sdat_b[2], 32'h33333333);
    check("div1_gap", scyc_b[1] - scyc_b[0], 64);
    check("div1_width", werr_b, 0);
    check("div1_done", done_b, 1);
    check("div1_words", words_b, 3);
    check("sclk_cs_b", viol_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
